// File: rtl/fft_loader_pkg.sv
// rtl/fft_loader_pkg.sv - shared types and constants for the FFT frame loader
package fft_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_START,
        ST_WAIT
    } loader_state_t;

    // Code 3 is reserved and decodes as CH_LEFT in the conditioner.
    typedef enum logic [1:0] {
        CH_LEFT  = 2'd0,
        CH_RIGHT = 2'd1,
        CH_AVG   = 2'd2
    } ch_mode_t;

    localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/sample_conditioner.sv
// rtl/sample_conditioner.sv - channel select/mix, then round and saturate PCM to FFT width
module sample_conditioner
    import fft_loader_pkg::*;
#(
    parameter int DATA_RES  = 24,
    parameter int BIT_WIDTH = 16
) (
    input  logic        [1:0]           ch_mode_i,
    input  logic signed [DATA_RES-1:0]  left_i,
    input  logic signed [DATA_RES-1:0]  right_i,
    output logic signed [BIT_WIDTH-1:0] sample_o
);

    localparam int SH = DATA_RES - BIT_WIDTH;
    localparam logic signed [DATA_RES+1:0] HALF    = (DATA_RES+2)'(2**(SH-1));
    localparam logic signed [DATA_RES+1:0] SAT_MAX = (DATA_RES+2)'(2**(BIT_WIDTH-1) - 1);
    localparam logic signed [DATA_RES+1:0] SAT_MIN = ~SAT_MAX;

    logic signed [DATA_RES:0]   sum;
    logic signed [DATA_RES:0]   sel;
    logic signed [DATA_RES+1:0] rounded;
    logic signed [DATA_RES+1:0] shifted;

    always_comb begin
        sum = {left_i[DATA_RES-1], left_i} + {right_i[DATA_RES-1], right_i};
        case (ch_mode_t'(ch_mode_i))
            CH_RIGHT: sel = {right_i[DATA_RES-1], right_i};
            CH_AVG:   sel = sum >>> 1;
            default:  sel = {left_i[DATA_RES-1], left_i};
        endcase
        // Guard bit keeps the +half from wrapping at full-scale positive input.
        rounded = {sel[DATA_RES], sel} + HALF;
        shifted = rounded >>> SH;
        if (shifted > SAT_MAX) begin
            sample_o = SAT_MAX[BIT_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            sample_o = SAT_MIN[BIT_WIDTH-1:0];
        end else begin
            sample_o = shifted[BIT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fft_frame_loader.sv
// rtl/fft_frame_loader.sv - streams N conditioned stereo samples into the FFT and sequences start/done
module fft_frame_loader
    import fft_loader_pkg::*;
#(
    parameter int DATA_RES  = 24,
    parameter int BIT_WIDTH = 16,
    parameter int M         = 9,
    parameter int N         = 1 << M,
    parameter int DECIM_W   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable_i,
    input  logic                       continuous_i,
    input  logic [1:0]                 ch_mode_i,
    input  logic [DECIM_W-1:0]         decim_i,
    input  logic signed [DATA_RES-1:0] left_i,
    input  logic signed [DATA_RES-1:0] right_i,
    input  logic                       sample_stb_i,
    output logic                       fft_load_o,
    output logic [M-1:0]               fft_adr_o,
    output logic [2*BIT_WIDTH-1:0]     fft_rd_o,
    output logic                       fft_start_o,
    input  logic                       fft_done_i,
    output logic                       frame_done_o,
    output logic                       busy_o,
    input  logic                       clear_ovr_i,
    output logic                       overrun_o,
    output logic [DROP_CNT_W-1:0]      drop_cnt_o
);

    loader_state_t               state_q, state_d;
    logic [M-1:0]                cnt_q, cnt_d;
    logic [DECIM_W-1:0]          dec_q, dec_d;
    logic                        load_q, load_d;
    logic [M-1:0]                adr_q, adr_d;
    logic [2*BIT_WIDTH-1:0]      rd_q, rd_d;
    logic                        start_q, start_d;
    logic                        frame_done_q, frame_done_d;
    logic                        ovr_q, ovr_d;
    logic [DROP_CNT_W-1:0]       drop_q, drop_d;

    logic signed [BIT_WIDTH-1:0] cond_sample;
    logic                        keep;
    logic                        drop;
    logic [DECIM_W-1:0]          dec_adv;

    sample_conditioner #(
        .DATA_RES  (DATA_RES),
        .BIT_WIDTH (BIT_WIDTH)
    ) u_cond (
        .ch_mode_i (ch_mode_i),
        .left_i    (left_i),
        .right_i   (right_i),
        .sample_o  (cond_sample)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dec_d        = dec_q;
        load_d       = 1'b0;
        adr_d        = adr_q;
        rd_d         = rd_q;
        start_d      = 1'b0;
        frame_done_d = 1'b0;
        ovr_d        = ovr_q;
        drop_d       = drop_q;
        drop         = 1'b0;
        keep         = sample_stb_i && (dec_q == '0);
        dec_adv      = (dec_q >= decim_i) ? '0 : dec_q + DECIM_W'(1);

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                dec_d = '0;
                if (enable_i) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    dec_d   = '0;
                end else if (sample_stb_i) begin
                    dec_d = dec_adv;
                    if (keep) begin
                        load_d = 1'b1;
                        adr_d  = cnt_q;
                        rd_d   = {cond_sample, {BIT_WIDTH{1'b0}}};
                        cnt_d  = cnt_q + M'(1);
                        if (cnt_q == M'(N-1)) state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                start_d = 1'b1;
                state_d = ST_WAIT;
                drop    = keep;
                if (sample_stb_i) dec_d = dec_adv;
            end
            ST_WAIT: begin
                drop = keep;
                if (sample_stb_i) dec_d = dec_adv;
                if (fft_done_i) begin
                    frame_done_d = 1'b1;
                    if (continuous_i && enable_i) begin
                        state_d = ST_FILL;
                        cnt_d   = '0;
                        dec_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A drop in the same cycle as a clear restarts the count at one.
        if (drop) begin
            ovr_d = 1'b1;
            if (clear_ovr_i) begin
                drop_d = DROP_CNT_W'(1);
            end else if (drop_q != {DROP_CNT_W{1'b1}}) begin
                drop_d = drop_q + DROP_CNT_W'(1);
            end
        end else if (clear_ovr_i) begin
            ovr_d  = 1'b0;
            drop_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            dec_q        <= '0;
            load_q       <= 1'b0;
            adr_q        <= '0;
            rd_q         <= '0;
            start_q      <= 1'b0;
            frame_done_q <= 1'b0;
            ovr_q        <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dec_q        <= dec_d;
            load_q       <= load_d;
            adr_q        <= adr_d;
            rd_q         <= rd_d;
            start_q      <= start_d;
            frame_done_q <= frame_done_d;
            ovr_q        <= ovr_d;
            drop_q       <= drop_d;
        end
    end

    assign fft_load_o   = load_q;
    assign fft_adr_o    = adr_q;
    assign fft_rd_o     = rd_q;
    assign fft_start_o  = start_q;
    assign frame_done_o = frame_done_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign overrun_o    = ovr_q;
    assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// tb/tb_fft_frame_loader.sv - scoreboard bench for fft_frame_loader with N=8
module tb_fft_frame_loader;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_i, continuous_i, sample_stb_i, fft_done_i, clear_ovr_i;
    logic [1:0]  ch_mode_i;
    logic [3:0]  decim_i;
    logic [23:0] left_i, right_i;
    logic        fft_load_o, fft_start_o, frame_done_o, busy_o, overrun_o;
    logic [2:0]  fft_adr_o;
    logic [31:0] fft_rd_o;
    logic [7:0]  drop_cnt_o;

    always #5 clk = ~clk;

    fft_frame_loader #(
        .DATA_RES(24), .BIT_WIDTH(16), .M(3), .N(N), .DECIM_W(4)
    ) dut (
        .clk(clk), .reset(reset), .enable_i(enable_i), .continuous_i(continuous_i),
        .ch_mode_i(ch_mode_i), .decim_i(decim_i), .left_i(left_i), .right_i(right_i),
        .sample_stb_i(sample_stb_i), .fft_load_o(fft_load_o), .fft_adr_o(fft_adr_o),
        .fft_rd_o(fft_rd_o), .fft_start_o(fft_start_o), .fft_done_i(fft_done_i),
        .frame_done_o(frame_done_o), .busy_o(busy_o), .clear_ovr_i(clear_ovr_i),
        .overrun_o(overrun_o), .drop_cnt_o(drop_cnt_o)
    );

    typedef struct { logic [2:0] adr; logic [31:0] rd; } exp_t;
    typedef struct { logic [23:0] l; logic [23:0] r; int ex; } pre_t;

    exp_t exp_q[$];
    pre_t pre_q[$];
    int checks = 0, errors = 0, cyc = 0;
    int starts = 0, dones = 0, exp_starts = 0, exp_dones = 0;
    int last_load_cyc = -10;
    logic [2:0] last_load_adr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: pick/mix channel, divide by 256 rounding half up, clamp to 16-bit signed.
    function automatic logic [15:0] ref_cond(input int mode, input logic [23:0] l, input logic [23:0] r);
        int li, ri, v, q;
        li = int'($signed(l));
        ri = int'($signed(r));
        if (mode == 1) v = ri;
        else if (mode == 2) v = fdiv(li + ri, 2);
        else v = li;
        q = fdiv(v + 128, 256);
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q[15:0];
    endfunction

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!reset) begin
            if (fft_load_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_load", 32'(fft_adr_o), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("load_adr", 32'(fft_adr_o), 32'(e.adr));
                    check("load_rd", fft_rd_o, e.rd);
                end
                last_load_adr = fft_adr_o;
                last_load_cyc = cyc;
            end
            if (fft_start_o) begin
                starts++;
                check("start_after_last_adr", 32'(last_load_adr), 32'(N-1));
                check("start_latency", 32'(cyc - last_load_cyc), 32'd1);
            end
            if (frame_done_o) dones++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] l, input logic [23:0] r);
        left_i = l;
        right_i = r;
        sample_stb_i = 1'b1;
        step();
        sample_stb_i = 1'b0;
    endtask

    task automatic fill_frame(input int n_keep, input int decim, input int gap_max);
        int kept, i, e;
        logic [23:0] l, r;
        pre_t p;
        exp_t x;
        kept = 0;
        i = 0;
        while (kept < n_keep) begin
            l = 24'($urandom);
            r = 24'($urandom);
            if (i % (decim + 1) == 0) begin
                e = -1;
                if (pre_q.size() > 0) begin
                    p = pre_q.pop_front();
                    l = p.l;
                    r = p.r;
                    e = p.ex;
                end
                x.adr = 3'(kept);
                x.rd = {(e < 0) ? ref_cond(int'(ch_mode_i), l, r) : 16'(e), 16'h0000};
                exp_q.push_back(x);
                kept++;
            end
            send(l, r);
            i++;
            if (kept < n_keep) repeat ($urandom_range(gap_max, 0)) step();
        end
    endtask

    task automatic wait_start();
        int t;
        t = 0;
        while (starts < exp_starts && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("start_seen", 32'(starts), 32'(exp_starts));
    endtask

    task automatic do_done();
        step();
        fft_done_i = 1'b1;
        step();
        fft_done_i = 1'b0;
        exp_dones++;
        @(negedge clk);
        check("frame_done_pulse", 32'(frame_done_o), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_load"}, 32'(fft_load_o), 0);
        check({tag, "_adr"}, 32'(fft_adr_o), 0);
        check({tag, "_rd"}, fft_rd_o, 0);
        check({tag, "_start"}, 32'(fft_start_o), 0);
        check({tag, "_frame_done"}, 32'(frame_done_o), 0);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_overrun"}, 32'(overrun_o), 0);
        check({tag, "_drop_cnt"}, 32'(drop_cnt_o), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        enable_i = 0; continuous_i = 0; sample_stb_i = 0; fft_done_i = 0; clear_ovr_i = 0;
        ch_mode_i = 2'd0; decim_i = 4'd0; left_i = '0; right_i = '0;
        @(negedge clk);
        check_reset_outputs("reset");
        step();
        reset = 1'b0;
        step();

        // Single shot ramp: left = 0x100*k gives real = k.
        for (int k = 0; k < N; k++) pre_q.push_back('{24'(k * 256), 24'h0, k});
        enable_i = 1'b1;
        step();
        fill_frame(N, 0, 0);
        exp_starts++;
        wait_start();
        do_done();
        check("single_shot_idle_busy", 32'(busy_o), 0);

        // Rounding and saturation corners.
        ch_mode_i = 2'd2;
        pre_q.push_back('{24'h7FFFFF, 24'h7FFFFF, 32'h7FFF});
        step();
        fill_frame(N, 0, 1);
        exp_starts++;
        wait_start();
        do_done();
        ch_mode_i = 2'd0;
        pre_q.push_back('{24'h000080, 24'h0, 1});
        pre_q.push_back('{24'h800000, 24'h0, 32'h8000});
        pre_q.push_back('{24'h00007F, 24'h0, 0});
        step();
        fill_frame(N, 0, 1);
        exp_starts++;
        wait_start();
        do_done();

        // Decimation by 3: 22 strobes fill the frame, 2 trailing strobes are skipped, not dropped.
        decim_i = 4'd2;
        step();
        fill_frame(N, 2, 0);
        send(24'h1, 24'h1);
        send(24'h2, 24'h2);
        exp_starts++;
        wait_start();
        check("decim_no_drops", 32'(drop_cnt_o), 0);
        check("decim_no_overrun", 32'(overrun_o), 0);
        do_done();
        decim_i = 4'd0;

        // Randomized frames.
        for (int f = 0; f < 4; f++) begin
            ch_mode_i = 2'($urandom_range(3, 0));
            decim_i = 4'($urandom_range(3, 0));
            step();
            fill_frame(N, int'(decim_i), 2);
            exp_starts++;
            wait_start();
            do_done();
            check("rand_frame_idle", 32'(busy_o), 0);
        end
        decim_i = 4'd0;
        ch_mode_i = 2'd1;

        // Overrun in continuous mode.
        continuous_i = 1'b1;
        step();
        fill_frame(N, 0, 0);
        exp_starts++;
        wait_start();
        for (int d = 0; d < 5; d++) send(24'($urandom), 24'($urandom));
        @(negedge clk);
        check("overrun_set", 32'(overrun_o), 1);
        check("drop_cnt_5", 32'(drop_cnt_o), 5);
        do_done();
        fill_frame(N, 0, 0);
        exp_starts++;
        wait_start();
        clear_ovr_i = 1'b1;
        send(24'h123456, 24'h654321);
        clear_ovr_i = 1'b0;
        @(negedge clk);
        check("clear_drop_ovr", 32'(overrun_o), 1);
        check("clear_drop_cnt", 32'(drop_cnt_o), 1);
        continuous_i = 1'b0;
        do_done();
        check("cont_off_idle", 32'(busy_o), 0);
        clear_ovr_i = 1'b1;
        step();
        clear_ovr_i = 1'b0;
        @(negedge clk);
        check("cleared_ovr", 32'(overrun_o), 0);
        check("cleared_cnt", 32'(drop_cnt_o), 0);

        // Abort after 4 loads, then restart from address 0.
        ch_mode_i = 2'd0;
        step();
        fill_frame(4, 0, 1);
        enable_i = 1'b0;
        step();
        @(negedge clk);
        check("abort_idle", 32'(busy_o), 0);
        repeat (10) step();
        check("abort_no_start", 32'(starts), 32'(exp_starts));
        enable_i = 1'b1;
        step();
        fill_frame(N, 0, 0);
        exp_starts++;
        wait_start();
        do_done();

        // Asynchronous reset while waiting for the FFT.
        step();
        fill_frame(N, 0, 0);
        exp_starts++;
        wait_start();
        send(24'h0ABCDE, 24'h0);
        @(negedge clk);
        check("pre_reset_overrun", 32'(overrun_o), 1);
        #2;
        reset = 1'b1;
        enable_i = 1'b0;
        fft_done_i = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        repeat (3) step();
        reset = 1'b0;
        repeat (5) step();
        fft_done_i = 1'b0;
        step();

        @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        check("start_count", 32'(starts), 32'(exp_starts));
        check("done_count", 32'(dones), 32'(exp_dones));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_frame_loader.md
# fft_frame_loader

Parametrised successor to the single-channel I2S-to-FFT wrapper. It takes stereo PCM samples from the I2S receiver, already strobed into the `clk` domain. It selects or mixes channels, optionally decimates, and rounds and saturates each sample to FFT width. It then streams exactly N samples into the FFT load port, issues `start`, waits for `done`, and repeats in continuous mode, flagging any samples it had to drop.

## Interface
**Parameters**
- DATA_RES, 24: PCM sample width from the I2S receiver (signed); must be greater than BIT_WIDTH.
- BIT_WIDTH, 16: FFT real/imag component width.
- M, 9: log2 of the frame length.
- N, 1<<M: frame length in samples.
- DECIM_W, 4: width of the decimation-factor input.

**Ports**
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable_i  in  1  arm capture (level).
- continuous_i  in  1  1 = refill automatically after each FFT; 0 = single shot.
- ch_mode_i  in  2  0 = left, 1 = right, 2 = (L+R)/2, 3 = reserved (treated as left).
- decim_i  in  DECIM_W  keep 1 of every decim_i+1 strobes.
- left_i, right_i  in  DATA_RES  signed PCM, valid when sample_stb_i is high.
- sample_stb_i  in  1  one-cycle strobe per stereo sample.
- fft_load_o  out  1  write strobe to the FFT sample memory.
- fft_adr_o  out  M  write address.
- fft_rd_o  out  2*BIT_WIDTH  packed {real, imag}, with imag = 0.
- fft_start_o  out  1  one-cycle FFT start pulse.
- fft_done_i  in  1  FFT done (level; sampled only in WAIT).
- frame_done_o  out  1  one-cycle pulse when the FFT completes.
- busy_o  out  1  high in any state other than IDLE.
- clear_ovr_i  in  1  clears overrun_o and drop_cnt_o.
- overrun_o  out  1  sticky flag: a kept sample was dropped.
- drop_cnt_o  out  8  count of dropped kept samples; saturates at 255.

## Operation
**FSM states:** IDLE, FILL, START, WAIT.
- **IDLE:** enable_i=1 → FILL. The sample count and decimation counter are cleared on entry.
- **FILL:**
  - Each strobe advances the decimation counter: it counts 0..decim_i and wraps. A strobe is kept when the counter is 0.
  - A kept sample is conditioned and written to address `cnt`, then `cnt` increments.
  - After the write to N-1 → START.
  - enable_i=0 in FILL aborts the frame → IDLE. No start is issued and `cnt` resets.
- **START:** assert fft_start_o for one cycle → WAIT.
- **WAIT:**
  - When fft_done_i=1: pulse frame_done_o, then go to FILL if (continuous_i & enable_i), else IDLE.
  - enable_i=0 in WAIT does not abort; the FFT finishes first.
- **Drops:** kept strobes arriving in START or WAIT are dropped. Each drop sets overrun_o and increments drop_cnt_o. Strobes arriving in IDLE are ignored and do not count as drops.
- **Conditioning** (all signed arithmetic):
  - Mix: mode 2 computes (L+R) in DATA_RES+1 bits, then an arithmetic shift right by 1.
  - Round: add 2^(DATA_RES-BIT_WIDTH-1), arithmetic shift right by DATA_RES-BIT_WIDTH, with an extra guard bit.
  - Saturate to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1].
- **clear_ovr_i and a drop in the same cycle:** the drop wins, giving overrun_o=1 and drop_cnt_o=1.
- **ch_mode_i and decim_i:** sampled on each strobe. Software changes them only in IDLE.

## Timing
- **Reset values:** state=IDLE; fft_load_o=0; fft_adr_o=0; fft_rd_o=0; fft_start_o=0; frame_done_o=0; busy_o=0; overrun_o=0; drop_cnt_o=0.
- **Write latency:** the strobe is at cycle t; fft_load_o, fft_adr_o and fft_rd_o are registered and valid for exactly one cycle at t+1.
- **Back-to-back strobes** on every cycle are supported, with one write per cycle.
- **Start timing:** fft_start_o is asserted in the cycle after the N-1 write.
- **Completion:** frame_done_o is asserted in the cycle after fft_done_i is seen in WAIT.
- **Re-entry:** FILL re-entry is immediate, so the next kept strobe writes address 0.
- **Async reset** mid-frame drops everything, including the pending load pulse.

## Structure
- Package `fft_loader_pkg`: `loader_state_t` enum, `ch_mode_t` enum (CH_LEFT, CH_RIGHT, CH_AVG), and a constant for the drop-counter width.
- Sub-module `sample_conditioner`: purely combinational channel select/mix plus round/saturate, parametrised by DATA_RES and BIT_WIDTH.
- Top-level: FSM, address and decimation counters, output registers, drop counter.

## Test plan
All scenarios use DATA_RES=24, BIT_WIDTH=16 and M=3 (N=8).
- **Fill and single shot:** ch_mode=0, decim=0, continuous=0, left = 0x000100·k for k=0..7.
  - Expect 8 loads at addresses 0..7 with real = k, imag = 0.
  - Expect fft_start_o 1 cycle after the last load.
  - Drive fft_done_i=1: expect frame_done_o, then IDLE with busy_o=0.
- **Rounding/saturation:** mode 2 with L=R=0x7FFFFF gives real 0x7FFF. L=0x000080 gives real 1 (round half up). L=0x800000 gives 0x8000. L=0x00007F gives 0.
- **Decimation:** decim=2 with 24 strobes gives exactly 8 loads, taken from strobes 0, 3, 6, …, 21.
- **Overrun:** continuous=1; hold fft_done_i low for 5 kept strobes in WAIT.
  - Expect overrun_o=1 and drop_cnt_o=5.
  - After done, the next kept strobe writes address 0.
  - clear_ovr_i returns both flags to 0.
- **Abort:** drop enable_i after 4 loads.
  - Expect IDLE with no fft_start_o.
  - Re-enabling restarts at address 0.
- **Reset mid-WAIT:** all outputs take their reset values in the same cycle, and no frame_done_o follows.
